gpio_mmio: RTL and testbench
============================

# gpio_mmio

Memory-mapped 8-bit GPIO peripheral for the multicycle MIPS core (CoreMips). It decodes the core's data-memory address, write data and write strobe, and drives the external GPIO_o pins. It samples the external GPIO_i pins through a two-flop synchronizer and a per-bit debounce filter, then returns the filtered value on the core's read-data path. Sticky rising-edge flags let software poll for button presses without missing short events.

## Interface
- BASE_ADDR, 32'h1001_0000, base of the 16-byte register window; must be 16-byte aligned.
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized input bit must differ from its stable value before the change is accepted; legal range 1..255.
- clk  input  1  core clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- addr  input  32  byte address from the core's memory address mux.
- wdata  input  32  store data from the core.
- we  input  1  memory write strobe from the control unit.
- hit  output  1  high when addr[31:4] == BASE_ADDR[31:4]; combinational.
- rdata  output  32  read data; combinational; 32'h0 when hit is low.
- GPIO_i  input  8  raw asynchronous input pins.
- GPIO_o  output  8  output pins; registered.

## Operation
- Register map, offset = addr[3:2]; addr[1:0] are ignored:
  - 0: IN. Read-only. rdata = {24'h0, stable[7:0]}. Writes are ignored.
  - 1: OUT. Read/write. rdata = {24'h0, out_q}. A write loads wdata[7:0]; wdata[31:8] are ignored.
  - 2: EDGE. rdata = {24'h0, edge_q}. A write clears each bit where wdata[i]=1 (write-1-to-clear).
  - 3: reserved. Reads return 0; writes are ignored.
- A write takes effect only when we=1 and hit=1.
- Synchronizer: s1 <= GPIO_i; s2 <= s1.
- Per-bit debounce, counter cnt[i] of 8 bits:
  - If s2[i] == stable[i], then cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1, then stable[i] <= s2[i] and cnt[i] <= 0.
  - Else cnt[i] <= cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles resets the count and never reaches stable.
- Edge detect: edge_q[i] is set on the clock edge where stable[i] goes 0->1. Falling transitions never set a flag.
- If a set and a write-1-to-clear hit the same bit on the same edge, the set wins and the bit stays 1.
- GPIO_o = out_q directly; no combinational path from wdata.

## Timing
- Reset (rst low, asynchronous): s1, s2, stable, cnt, out_q and edge_q all go to 0. Therefore GPIO_o=0 and IN/EDGE read 0.
- Reset asserted mid-debounce discards the partial count. After release, filtering restarts from stable=0.
- Read latency is 0 cycles: rdata follows addr combinationally, matching the core's asynchronous memory read. The core latches it into MDR on the next edge.
- Write latency: a write on edge k makes GPIO_o and the OUT/EDGE readback show the new value after edge k.
- Input latency, for GPIO_i changing before edge 1 and then held:
  - s2 shows the new value after edge 2.
  - stable updates at edge 2+DEBOUNCE_CYCLES.
  - Default N=4: IN readback changes after edge 6. N=1: after edge 3.
- edge_q is set on the same edge as the stable 0->1 update.
- Reading a register has no side effects.

## Test plan
- Reset: hold rst=0 with GPIO_i=8'hFF for 10 cycles -> GPIO_o=0, IN=0, EDGE=0. Release rst -> IN reads 8'hFF after edge 6 and EDGE=8'hFF.
- OUT write: we=1, addr=BASE+4, wdata=32'hDEAD_BEA5 -> GPIO_o=8'hA5 after one edge; reading BASE+4 returns 32'h0000_00A5. Writing BASE+0 or addr=BASE+16 -> GPIO_o unchanged.
- Debounce: GPIO_i bit0 pulsed high for 3 cycles with N=4 -> IN stays 0 and EDGE stays 0. Held for 4 or more cycles -> IN=1 exactly 6 edges after the rise.
- Edge flags: drive GPIO_i 0->8'h0F, then 8'h0F->8'h00 -> EDGE reads 8'h0F (the falling transition adds nothing). Write 32'h05 to BASE+8 -> EDGE reads 8'h0A.
- Simultaneous set/clear: time a write-1-to-clear to bit1 on the same edge that stable[1] rises -> EDGE bit1 remains 1.
- Decode: hit=0 and rdata=0 for addr=BASE-4 and BASE+16. Reading BASE+12 returns 0. BASE+5 aliases to OUT (addr[1:0] ignored).

Source files
------------

// File: rtl/gpio_mmio.sv
// gpio_mmio: 8-bit memory-mapped GPIO for the multicycle MIPS core.
// Drives registered output pins from the OUT register. Samples the input pins
// through a two-flop synchronizer and a per-bit debounce filter. Latches sticky
// rising-edge flags that software clears by writing ones (W1C).
//
// Bus semantics: there is no valid/ready handshake. A write is accepted on
// the rising clk edge where we=1 and hit=1, and the peripheral never stalls
// the core. Reads are combinational (rdata follows addr in the same cycle)
// and have no side effects.

module gpio_mmio #(
    parameter logic [31:0] BASE_ADDR       = 32'h1001_0000,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic        hit,
    output logic [31:0] rdata,
    input  logic [7:0]  GPIO_i,
    output logic [7:0]  GPIO_o
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] REG_IN   = 2'd0;
    localparam logic [1:0] REG_OUT  = 2'd1;
    localparam logic [1:0] REG_EDGE = 2'd2;

    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] stable;
    logic [7:0] stable_d;
    logic [7:0] cnt   [8];
    logic [7:0] cnt_d [8];
    logic [7:0] out_q;
    logic [7:0] edge_q;
    logic [7:0] edge_d;
    logic [7:0] clr_mask;
    logic [1:0] reg_sel;
    logic       wr_out;
    logic       wr_edge;

    // Byte-lane bits and the upper store data have no meaning in this block.
    logic       unused_bits;
    assign unused_bits = ^{addr[1:0], wdata[31:8]};

    assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel = addr[3:2];
    assign wr_out  = we && hit && (reg_sel == REG_OUT);
    assign wr_edge = we && hit && (reg_sel == REG_EDGE);
    assign GPIO_o  = out_q;

    // Per-bit debounce: count consecutive disagreeing cycles and accept the
    // new level only after DEBOUNCE_CYCLES of them; any agreement restarts.
    always_comb begin
        stable_d = stable;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt[i];
            if (s2[i] == stable[i]) begin
                cnt_d[i] = 8'd0;
            end else if (cnt[i] == CNT_LAST) begin
                stable_d[i] = s2[i];
                cnt_d[i]    = 8'd0;
            end else begin
                cnt_d[i] = cnt[i] + 8'd1;
            end
        end
    end

    // Edge flags: W1C clears first, then a fresh 0->1 sets; set wins a tie.
    always_comb begin
        clr_mask = wr_edge ? wdata[7:0] : 8'h00;
        edge_d   = (edge_q & ~clr_mask) | (stable_d & ~stable);
    end

    // Synchronizer, filter state, output and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1     <= 8'h00;
            s2     <= 8'h00;
            stable <= 8'h00;
            out_q  <= 8'h00;
            edge_q <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= 8'd0;
            end
        end else begin
            s1     <= GPIO_i;
            s2     <= s1;
            stable <= stable_d;
            edge_q <= edge_d;
            if (wr_out) begin
                out_q <= wdata[7:0];
            end
            for (int i = 0; i < 8; i++) begin
                cnt[i] <= cnt_d[i];
            end
        end
    end

    // Read mux: zero outside the window and for the reserved slot.
    always_comb begin
        rdata = 32'h0;
        if (hit) begin
            case (reg_sel)
                REG_IN:   rdata = {24'h0, stable};
                REG_OUT:  rdata = {24'h0, out_q};
                REG_EDGE: rdata = {24'h0, edge_q};
                default:  rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_mmio.sv
// Testbench for gpio_mmio: scenario tasks push expected values into exp_q as
// stimulus is driven and pop them when the DUT output is sampled.

module tb_gpio_mmio;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        hit;
    logic [31:0] rdata;
    logic [7:0]  GPIO_i;
    logic [7:0]  GPIO_o;

    int          errors;
    int          checks;
    logic [31:0] exp_q[$];
    logic [31:0] exp;
    logic [31:0] obs;
    logic        obs_hit;

    gpio_mmio dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .wdata  (wdata),
        .we     (we),
        .hit    (hit),
        .rdata  (rdata),
        .GPIO_i (GPIO_i),
        .GPIO_o (GPIO_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
        addr = a;
        we   = 1'b0;
        #1;
        d = rdata;
        h = hit;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        GPIO_i = 8'hFF;
        rst    = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if ({24'h0, GPIO_o} !== exp) begin
            errors++; $display("FAIL reset_gpio_o got=%h exp=%h", GPIO_o, exp[7:0]);
        end
        rd(BASE + 0, obs, obs_hit);
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL reset_in got=%h exp=%h", obs, exp);
        end
        rd(BASE + 8, obs, obs_hit);
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL reset_edge got=%h exp=%h", obs, exp);
        end
        // Release; the next rising edge is edge 1 of the input latency count.
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rd(BASE + 0, obs, obs_hit);
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL in_after_edge5 got=%h exp=%h", obs, exp);
        end
        @(posedge clk);
        #1;
        rd(BASE + 0, obs, obs_hit);
        exp_q.push_back(32'h0000_00FF);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL in_after_edge6 got=%h exp=%h", obs, exp);
        end
        rd(BASE + 8, obs, obs_hit);
        exp_q.push_back(32'h0000_00FF);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL edge_after_release got=%h exp=%h", obs, exp);
        end
        // Return inputs low (falling: no new flags) and clear all flags.
        @(negedge clk);
        GPIO_i = 8'h00;
        repeat (8) @(posedge clk);
        wr(BASE + 8, 32'hFFFF_FFFF);
        rd(BASE + 8, obs, obs_hit);
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL edge_clear_all got=%h exp=%h", obs, exp);
        end
    endtask

    task automatic test_out_write;
        wr(BASE + 4, 32'hDEAD_BEA5);
        exp_q.push_back(32'h0000_00A5);
        exp = exp_q.pop_front(); checks++;
        if ({24'h0, GPIO_o} !== exp) begin
            errors++; $display("FAIL out_gpio_o got=%h exp=%h", GPIO_o, exp[7:0]);
        end
        rd(BASE + 4, obs, obs_hit);
        exp_q.push_back(32'h0000_00A5);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL out_readback got=%h exp=%h", obs, exp);
        end
        // Writes to IN, reserved and outside the window must not touch OUT.
        wr(BASE + 0, 32'h0000_0033);
        wr(BASE + 12, 32'h0000_0044);
        wr(BASE + 16, 32'h0000_0077);
        wr(BASE - 12, 32'h0000_0066);
        exp_q.push_back(32'h0000_00A5);
        exp = exp_q.pop_front(); checks++;
        if ({24'h0, GPIO_o} !== exp) begin
            errors++; $display("FAIL out_unchanged got=%h exp=%h", GPIO_o, exp[7:0]);
        end
        // Byte offset within the word is ignored: BASE+5 is OUT.
        wr(BASE + 5, 32'h1234_565A);
        exp_q.push_back(32'h0000_005A);
        exp = exp_q.pop_front(); checks++;
        if ({24'h0, GPIO_o} !== exp) begin
            errors++; $display("FAIL out_alias_write got=%h exp=%h", GPIO_o, exp[7:0]);
        end
    endtask

    task automatic test_debounce;
        logic seen_in;
        logic seen_edge;
        seen_in   = 1'b0;
        seen_edge = 1'b0;
        // 3-cycle pulse on bit0: one short of the filter length.
        @(negedge clk);
        GPIO_i = 8'h01;
        repeat (3) @(negedge clk);
        GPIO_i = 8'h00;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            rd(BASE + 0, obs, obs_hit);
            if (obs != 32'h0) seen_in = 1'b1;
            rd(BASE + 8, obs, obs_hit);
            if (obs != 32'h0) seen_edge = 1'b1;
        end
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if ({31'h0, seen_in} !== exp) begin
            errors++; $display("FAIL glitch_in got=%0d exp=%0d", seen_in, exp[0]);
        end
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if ({31'h0, seen_edge} !== exp) begin
            errors++; $display("FAIL glitch_edge got=%0d exp=%0d", seen_edge, exp[0]);
        end
        // Held high: accepted exactly on the sixth edge after the change.
        @(negedge clk);
        GPIO_i = 8'h01;
        repeat (5) @(posedge clk);
        #1;
        rd(BASE + 0, obs, obs_hit);
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL held_in_edge5 got=%h exp=%h", obs, exp);
        end
        @(posedge clk);
        #1;
        rd(BASE + 0, obs, obs_hit);
        exp_q.push_back(32'h0000_0001);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL held_in_edge6 got=%h exp=%h", obs, exp);
        end
        rd(BASE + 8, obs, obs_hit);
        exp_q.push_back(32'h0000_0001);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL held_edge got=%h exp=%h", obs, exp);
        end
        @(negedge clk);
        GPIO_i = 8'h00;
        repeat (8) @(posedge clk);
        wr(BASE + 8, 32'h0000_0001);
    endtask

    task automatic test_edge_flags;
        @(negedge clk);
        GPIO_i = 8'h0F;
        repeat (8) @(posedge clk);
        @(negedge clk);
        GPIO_i = 8'h00;
        repeat (8) @(posedge clk);
        #1;
        rd(BASE + 8, obs, obs_hit);
        exp_q.push_back(32'h0000_000F);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL edge_rise_fall got=%h exp=%h", obs, exp);
        end
        wr(BASE + 8, 32'h0000_0005);
        rd(BASE + 8, obs, obs_hit);
        exp_q.push_back(32'h0000_000A);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL edge_w1c got=%h exp=%h", obs, exp);
        end
        wr(BASE + 8, 32'h0000_00FF);
    endtask

    task automatic test_set_clear;
        // Clear of bit1 lands on edge 6, the same edge stable[1] rises.
        @(negedge clk);
        GPIO_i = 8'h02;
        repeat (5) @(posedge clk);
        @(negedge clk);
        addr  = BASE + 8;
        wdata = 32'h0000_0002;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
        rd(BASE + 8, obs, obs_hit);
        exp_q.push_back(32'h0000_0002);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL set_wins got=%h exp=%h", obs, exp);
        end
        wr(BASE + 8, 32'h0000_0002);
        rd(BASE + 8, obs, obs_hit);
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL clear_after_set got=%h exp=%h", obs, exp);
        end
    endtask

    task automatic test_decode;
        // Inputs currently debounced to 8'h02, OUT holds 8'h5A.
        rd(BASE - 4, obs, obs_hit);
        exp_q.push_back({1'b0, 31'h0});
        exp = exp_q.pop_front(); checks++;
        if ({obs_hit, obs[30:0]} !== exp || obs[31] !== 1'b0) begin
            errors++; $display("FAIL decode_below got hit=%0d rdata=%h exp hit=0 rdata=0", obs_hit, obs);
        end
        rd(BASE + 16, obs, obs_hit);
        exp_q.push_back({1'b0, 31'h0});
        exp = exp_q.pop_front(); checks++;
        if ({obs_hit, obs[30:0]} !== exp || obs[31] !== 1'b0) begin
            errors++; $display("FAIL decode_above got hit=%0d rdata=%h exp hit=0 rdata=0", obs_hit, obs);
        end
        rd(BASE + 0, obs, obs_hit);
        exp_q.push_back(32'h0000_0002);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp || obs_hit !== 1'b1) begin
            errors++; $display("FAIL decode_in got hit=%0d rdata=%h exp hit=1 rdata=%h", obs_hit, obs, exp);
        end
        rd(BASE + 12, obs, obs_hit);
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp || obs_hit !== 1'b1) begin
            errors++; $display("FAIL decode_reserved got hit=%0d rdata=%h exp hit=1 rdata=%h", obs_hit, obs, exp);
        end
        rd(BASE + 5, obs, obs_hit);
        exp_q.push_back(32'h0000_005A);
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL decode_alias got=%h exp=%h", obs, exp);
        end
    endtask

    task automatic test_random_out;
        logic [31:0] d;
        for (int i = 0; i < 6; i++) begin
            d = $urandom_range(32'hFFFF_FFFF, 0);
            wr(BASE + 4 + 32'($urandom_range(3, 0)), d);
            exp_q.push_back({24'h0, d[7:0]});
            rd(BASE + 4, obs, obs_hit);
            exp = exp_q.pop_front(); checks++;
            if (obs !== exp || {24'h0, GPIO_o} !== exp) begin
                errors++; $display("FAIL random_out rdata=%h gpio_o=%h exp=%h", obs, GPIO_o, exp);
            end
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        errors = 0;
        checks = 0;
        addr   = 32'h0;
        wdata  = 32'h0;
        we     = 1'b0;
        GPIO_i = 8'h00;
        rst    = 1'b0;
        test_reset();
        test_out_write();
        test_debounce();
        test_edge_flags();
        test_set_clear();
        test_decode();
        test_random_out();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
